// File: rtl/soc_pkg.sv
// -----------------------------------------------------------------------------
// soc_pkg: types and constants shared by the BRAM bus arbiter slice.
//   ArbMaster   : master identifier (CPU = ArbM0, loader/DMA = ArbM1)
//   ArbReq      : one captured/selected bus request
//   ARB_MASTERS : number of arbitrated masters
//   ARB_ADDR_W  : storage width of the request address (the arbiter's AW <= 32)
// -----------------------------------------------------------------------------
package soc_pkg;

    localparam int ARB_MASTERS = 2;
    localparam int ARB_ADDR_W  = 32;

    typedef enum logic {
        ArbM0 = 1'b0,
        ArbM1 = 1'b1
    } ArbMaster;

    typedef struct packed {
        logic [ARB_ADDR_W-1:0] addr;
        logic [31:0]           wdata;
        logic [3:0]            wmask;
        logic                  is_read;
        logic                  valid;
    } ArbReq;

    // A nonzero write mask makes the request a write, whatever rstrb says.
    function automatic logic arb_is_req(input logic rstrb, input logic [3:0] wmask);
        return rstrb | (|wmask);
    endfunction

endpackage

// File: rtl/arb_pending_slot.sv
// -----------------------------------------------------------------------------
// arb_pending_slot: per-master state of the BRAM arbiter.
//   Holds the deferred (pending) request, the registered rbusy/wbusy stalls and
//   the read-data hold register. A strobe issued while this master is stalled
//   is dropped and flagged by an assertion.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   addr_i..rstrb_i   master bus request inputs
//   defer_i           fresh request lost arbitration this cycle: capture it
//   grant_pend_i      pending request is granted this cycle: release it
//   rd_ret_i          this master's read was issued last cycle (data returns now)
//   ram_rdata_i       BRAM read data
//   fresh_o           this cycle's fresh request (valid only when not stalled)
//   pend_o            pending latch contents
//   rbusy_o, wbusy_o  registered stalls
//   rdata_o           read data to the master
// -----------------------------------------------------------------------------
module arb_pending_slot
    import soc_pkg::*;
#(
    parameter int AW = 20
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    input  logic [3:0]    wmask_i,
    input  logic          rstrb_i,
    input  logic          defer_i,
    input  logic          grant_pend_i,
    input  logic          rd_ret_i,
    input  logic [31:0]   ram_rdata_i,
    output ArbReq         fresh_o,
    output ArbReq         pend_o,
    output logic          rbusy_o,
    output logic          wbusy_o,
    output logic [31:0]   rdata_o
);

    ArbReq       fresh;
    ArbReq       pend_d, pend_q;
    logic        rbusy_q, wbusy_q;
    logic [31:0] hold_q;
    logic        req;

    assign req = arb_is_req(rstrb_i, wmask_i);

    always_comb begin
        fresh         = '0;
        fresh.addr    = ARB_ADDR_W'(addr_i);
        fresh.wdata   = wdata_i;
        fresh.wmask   = wmask_i;
        fresh.is_read = ~(|wmask_i);
        // Strobes while stalled are dropped; the pending request stays as is.
        fresh.valid   = req & ~pend_q.valid;
    end

    always_comb begin
        pend_d = pend_q;
        if (grant_pend_i) begin
            pend_d.valid = 1'b0;
        end else if (defer_i) begin
            pend_d = fresh;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q  <= '0;
            rbusy_q <= 1'b0;
            wbusy_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            pend_q  <= pend_d;
            rbusy_q <= pend_d.valid & pend_d.is_read;
            wbusy_q <= pend_d.valid & ~pend_d.is_read;
            if (rd_ret_i) begin
                hold_q <= ram_rdata_i;
            end
        end
    end

    assign fresh_o = fresh;
    assign pend_o  = pend_q;
    assign rbusy_o = rbusy_q;
    assign wbusy_o = wbusy_q;
    // Returning data passes straight through and is also kept for later cycles.
    assign rdata_o = rd_ret_i ? ram_rdata_i : hold_q;

    a_no_strobe_while_busy: assert property (
        @(posedge clk) disable iff (!rst_n) !(req && pend_q.valid)
    );

endmodule

// File: rtl/ram_bus_arbiter.sv
// -----------------------------------------------------------------------------
// ram_bus_arbiter: two-master arbiter for the single-port SoC BRAM
// (FemtoRV32-style bus). Master 0 = CPU, master 1 = loader/DMA.
// One access per cycle; a pending request beats any fresh strobe, a fresh/fresh
// tie goes to the master selected by M1_PRIO, and the loser is held in its
// pending latch and stalled for one cycle.
// Parameters: AW (word-address width, <= 32), M1_PRIO (1 = master 1 wins ties).
// Ports:
//   clk, reset                      clock, asynchronous active-low reset
//   mX_addr/wdata/wmask/rstrb       master requests
//   mX_rdata/rbusy/wbusy            master responses and stalls
//   ram_addr/wdata/wmask/en         BRAM access (combinational from grant)
//   ram_rdata                       BRAM read data, one-cycle latency
// Optional: define ARB_STATS_EN to add conflict_count[15:0], a saturating count
// of cycles in which a request was deferred.
// -----------------------------------------------------------------------------
module ram_bus_arbiter
    import soc_pkg::*;
#(
    parameter int AW      = 20,
    parameter int M1_PRIO = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] m0_addr,
    input  logic [31:0]   m0_wdata,
    input  logic [3:0]    m0_wmask,
    input  logic          m0_rstrb,
    output logic [31:0]   m0_rdata,
    output logic          m0_rbusy,
    output logic          m0_wbusy,
    input  logic [AW-1:0] m1_addr,
    input  logic [31:0]   m1_wdata,
    input  logic [3:0]    m1_wmask,
    input  logic          m1_rstrb,
    output logic [31:0]   m1_rdata,
    output logic          m1_rbusy,
    output logic          m1_wbusy,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    output logic [3:0]    ram_wmask,
    output logic          ram_en,
    input  logic [31:0]   ram_rdata
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]   conflict_count
`endif
);

    ArbReq                  fresh [ARB_MASTERS];
    ArbReq                  pend  [ARB_MASTERS];
    ArbReq                  sel;
    ArbMaster               gnt_m;
    logic [ARB_MASTERS-1:0] defer, grant_pend;
    logic [ARB_MASTERS-1:0] grant_rd_d, grant_rd_q;

    arb_pending_slot #(.AW(AW)) u_slot_m0 (
        .clk          (clk),
        .rst_n        (reset),
        .addr_i       (m0_addr),
        .wdata_i      (m0_wdata),
        .wmask_i      (m0_wmask),
        .rstrb_i      (m0_rstrb),
        .defer_i      (defer[0]),
        .grant_pend_i (grant_pend[0]),
        .rd_ret_i     (grant_rd_q[0]),
        .ram_rdata_i  (ram_rdata),
        .fresh_o      (fresh[0]),
        .pend_o       (pend[0]),
        .rbusy_o      (m0_rbusy),
        .wbusy_o      (m0_wbusy),
        .rdata_o      (m0_rdata)
    );

    arb_pending_slot #(.AW(AW)) u_slot_m1 (
        .clk          (clk),
        .rst_n        (reset),
        .addr_i       (m1_addr),
        .wdata_i      (m1_wdata),
        .wmask_i      (m1_wmask),
        .rstrb_i      (m1_rstrb),
        .defer_i      (defer[1]),
        .grant_pend_i (grant_pend[1]),
        .rd_ret_i     (grant_rd_q[1]),
        .ram_rdata_i  (ram_rdata),
        .fresh_o      (fresh[1]),
        .pend_o       (pend[1]),
        .rbusy_o      (m1_rbusy),
        .wbusy_o      (m1_wbusy),
        .rdata_o      (m1_rdata)
    );

    // At most one latch is ever valid: a pending grant can only defer the other
    // master's fresh strobe, and the pending master's own strobes are dropped.
    always_comb begin
        sel        = '0;
        gnt_m      = ArbM0;
        defer      = '0;
        grant_pend = '0;
        if (pend[0].valid) begin
            sel           = pend[0];
            gnt_m         = ArbM0;
            grant_pend[0] = 1'b1;
            defer[1]      = fresh[1].valid;
        end else if (pend[1].valid) begin
            sel           = pend[1];
            gnt_m         = ArbM1;
            grant_pend[1] = 1'b1;
            defer[0]      = fresh[0].valid;
        end else if (fresh[0].valid && fresh[1].valid) begin
            if (M1_PRIO != 0) begin
                sel      = fresh[1];
                gnt_m    = ArbM1;
                defer[0] = 1'b1;
            end else begin
                sel      = fresh[0];
                gnt_m    = ArbM0;
                defer[1] = 1'b1;
            end
        end else if (fresh[0].valid) begin
            sel   = fresh[0];
            gnt_m = ArbM0;
        end else if (fresh[1].valid) begin
            sel   = fresh[1];
            gnt_m = ArbM1;
        end
    end

    always_comb begin
        grant_rd_d = '0;
        if (sel.valid && sel.is_read) begin
            grant_rd_d[gnt_m] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_rd_q <= '0;
        end else begin
            grant_rd_q <= grant_rd_d;
        end
    end

    // Enables are gated by reset so the BRAM sees no access while it is held.
    assign ram_en    = reset & sel.valid;
    assign ram_wmask = reset ? sel.wmask : '0;
    assign ram_addr  = AW'(sel.addr);
    assign ram_wdata = sel.wdata;

`ifdef ARB_STATS_EN
    logic [15:0] conflict_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            conflict_q <= '0;
        end else if ((|defer) && (conflict_q != 16'hFFFF)) begin
            conflict_q <= conflict_q + 16'd1;
        end
    end

    assign conflict_count = conflict_q;
`endif

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ram_bus_arbiter: directed self-checking bench for ram_bus_arbiter with a
// small behavioural BRAM (one-cycle registered read, byte-masked write).
// -----------------------------------------------------------------------------
module tb_ram_bus_arbiter;

    localparam int AW = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [31:0]   m0_wdata, m1_wdata;
    logic [3:0]    m0_wmask, m1_wmask;
    logic          m0_rstrb, m1_rstrb;
    logic [31:0]   m0_rdata, m1_rdata;
    logic          m0_rbusy, m1_rbusy, m0_wbusy, m1_wbusy;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [3:0]    ram_wmask;
    logic          ram_en;
    logic [31:0]   ram_rdata = '0;
`ifdef ARB_STATS_EN
    logic [15:0]   conflict_count;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    ram_bus_arbiter #(.AW(AW), .M1_PRIO(0)) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_wmask  (m0_wmask),
        .m0_rstrb  (m0_rstrb),
        .m0_rdata  (m0_rdata),
        .m0_rbusy  (m0_rbusy),
        .m0_wbusy  (m0_wbusy),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_wmask  (m1_wmask),
        .m1_rstrb  (m1_rstrb),
        .m1_rdata  (m1_rdata),
        .m1_rbusy  (m1_rbusy),
        .m1_wbusy  (m1_wbusy),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_wmask (ram_wmask),
        .ram_en    (ram_en),
        .ram_rdata (ram_rdata)
`ifdef ARB_STATS_EN
        ,
        .conflict_count (conflict_count)
`endif
    );

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wmask == 4'b0000) begin
                ram_rdata <= mem[ram_addr[7:0]];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_wmask[b]) mem[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
                end
            end
        end
    end

    // Start of a cycle: inputs change 1 time unit after the rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_rstrb = 1'b0; m0_wmask = 4'b0000;
        m1_rstrb = 1'b0; m1_wmask = 4'b0000;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        m0_addr = 20'h00010; m0_wdata = '0; m0_wmask = 4'b0000; m0_rstrb = 1'b1;
        m1_addr = 20'h00008; m1_wdata = '0; m1_wmask = 4'b1111; m1_rstrb = 1'b0;
        @(negedge clk);
        checks++;
        if (ram_en !== 1'b0) begin failures++; $display("FAIL reset_ram_en: got %b expected 0", ram_en); end
        checks++;
        if (ram_wmask !== 4'b0000) begin failures++; $display("FAIL reset_ram_wmask: got %b expected 0000", ram_wmask); end
        checks++;
        if ({m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy} !== 4'b0000) begin
            failures++; $display("FAIL reset_busy: got %b expected 0000", {m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy});
        end
        checks++;
        if ({m0_rdata, m1_rdata} !== 64'h0) begin
            failures++; $display("FAIL reset_rdata: got %h %h expected 0 0", m0_rdata, m1_rdata);
        end
        next_cycle();
        idle_inputs();
        reset = 1'b1;
    endtask

    task automatic test_uncontended_read();
        next_cycle();
        m0_addr = 20'h00010; m0_rstrb = 1'b1;
        @(negedge clk);
        checks++;
        if (ram_en !== 1'b1 || ram_addr !== 20'h00010) begin
            failures++; $display("FAIL uncont_issue: got en=%b addr=%h expected en=1 addr=00010", ram_en, ram_addr);
        end
        checks++;
        if (m0_rbusy !== 1'b0) begin failures++; $display("FAIL uncont_rbusy_n: got %b expected 0", m0_rbusy); end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (m0_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL uncont_data: got %h expected deadbeef", m0_rdata); end
        checks++;
        if (m0_rbusy !== 1'b0) begin failures++; $display("FAIL uncont_rbusy_n1: got %b expected 0", m0_rbusy); end
        next_cycle();
        @(negedge clk);
        checks++;
        if (m0_rdata !== 32'hDEADBEEF || ram_en !== 1'b0) begin
            failures++; $display("FAIL uncont_hold: got data=%h en=%b expected deadbeef 0", m0_rdata, ram_en);
        end
    endtask

    task automatic test_back_to_back();
        next_cycle();
        m0_addr = 20'h00010; m0_rstrb = 1'b1;
        next_cycle();
        m0_addr = 20'h00004; m0_rstrb = 1'b1;
        @(negedge clk);
        checks++;
        if (m0_rdata !== 32'hDEADBEEF || ram_addr !== 20'h00004) begin
            failures++; $display("FAIL b2b_first: got data=%h addr=%h expected deadbeef 00004", m0_rdata, ram_addr);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (m0_rdata !== 32'h44444444) begin failures++; $display("FAIL b2b_second: got %h expected 44444444", m0_rdata); end
    endtask

    task automatic test_read_tie();
        next_cycle();
        m0_addr = 20'h00004; m0_rstrb = 1'b1;
        m1_addr = 20'h00008; m1_rstrb = 1'b1;
        @(negedge clk);
        checks++;
        if (ram_addr !== 20'h00004 || m1_rbusy !== 1'b0) begin
            failures++; $display("FAIL tie_grant_n: got addr=%h m1_rbusy=%b expected 00004 0", ram_addr, m1_rbusy);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (m0_rdata !== 32'h44444444) begin failures++; $display("FAIL tie_m0_data: got %h expected 44444444", m0_rdata); end
        checks++;
        if (m1_rbusy !== 1'b1) begin failures++; $display("FAIL tie_m1_rbusy: got %b expected 1", m1_rbusy); end
        checks++;
        if (ram_en !== 1'b1 || ram_addr !== 20'h00008) begin
            failures++; $display("FAIL tie_m1_issue: got en=%b addr=%h expected 1 00008", ram_en, ram_addr);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (m1_rdata !== 32'h88888888 || m1_rbusy !== 1'b0) begin
            failures++; $display("FAIL tie_m1_data: got %h rbusy=%b expected 88888888 0", m1_rdata, m1_rbusy);
        end
        checks++;
        if (m0_rdata !== 32'h44444444) begin failures++; $display("FAIL tie_m0_hold: got %h expected 44444444", m0_rdata); end
        next_cycle();
        @(negedge clk);
        checks++;
        if (m1_rdata !== 32'h88888888 || ram_en !== 1'b0) begin
            failures++; $display("FAIL tie_m1_hold: got %h en=%b expected 88888888 0", m1_rdata, ram_en);
        end
    endtask

    task automatic test_write_read_tie();
        next_cycle();
        m1_addr = 20'h00020; m1_wdata = 32'h0000A5A5; m1_wmask = 4'b0011;
        m0_addr = 20'h00020; m0_rstrb = 1'b1;
        @(negedge clk);
        checks++;
        if (ram_wmask !== 4'b0000 || ram_en !== 1'b1) begin
            failures++; $display("FAIL wr_tie_read_first: got wmask=%b en=%b expected 0000 1", ram_wmask, ram_en);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (m0_rdata !== 32'h12345678) begin failures++; $display("FAIL wr_tie_old_data: got %h expected 12345678", m0_rdata); end
        checks++;
        if (m1_wbusy !== 1'b1 || m1_rbusy !== 1'b0) begin
            failures++; $display("FAIL wr_tie_wbusy: got w=%b r=%b expected 1 0", m1_wbusy, m1_rbusy);
        end
        checks++;
        if (ram_wmask !== 4'b0011 || ram_wdata !== 32'h0000A5A5 || ram_addr !== 20'h00020) begin
            failures++; $display("FAIL wr_tie_issue: got wmask=%b wdata=%h addr=%h expected 0011 0000a5a5 00020", ram_wmask, ram_wdata, ram_addr);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (m1_wbusy !== 1'b0) begin failures++; $display("FAIL wr_tie_wbusy_drop: got %b expected 0", m1_wbusy); end
        next_cycle();
        m0_addr = 20'h00020; m0_rstrb = 1'b1;
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (m0_rdata !== 32'h1234A5A5) begin failures++; $display("FAIL wr_tie_merged: got %h expected 1234a5a5", m0_rdata); end
    endtask

    task automatic test_pending_beats_fresh();
        next_cycle();
        m0_addr = 20'h00010; m0_rstrb = 1'b1;
        m1_addr = 20'h00004; m1_rstrb = 1'b1;
        next_cycle();
        m1_rstrb = 1'b0;
        m0_addr = 20'h00008; m0_rstrb = 1'b1;
        @(negedge clk);
        checks++;
        if (ram_addr !== 20'h00004 || m1_rbusy !== 1'b1 || m0_rbusy !== 1'b0) begin
            failures++; $display("FAIL pbf_pending_wins: got addr=%h m1_rbusy=%b m0_rbusy=%b expected 00004 1 0", ram_addr, m1_rbusy, m0_rbusy);
        end
        checks++;
        if (m0_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL pbf_m0_first: got %h expected deadbeef", m0_rdata); end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (m0_rbusy !== 1'b1 || ram_en !== 1'b1 || ram_addr !== 20'h00008) begin
            failures++; $display("FAIL pbf_m0_deferred: got rbusy=%b en=%b addr=%h expected 1 1 00008", m0_rbusy, ram_en, ram_addr);
        end
        checks++;
        if (m1_rdata !== 32'h44444444) begin failures++; $display("FAIL pbf_m1_data: got %h expected 44444444", m1_rdata); end
        next_cycle();
        @(negedge clk);
        checks++;
        if (m0_rdata !== 32'h88888888 || m0_rbusy !== 1'b0) begin
            failures++; $display("FAIL pbf_m0_data: got %h rbusy=%b expected 88888888 0", m0_rdata, m0_rbusy);
        end
    endtask

    task automatic test_reset_mid_defer();
        int en_seen;
        next_cycle();
        m0_addr = 20'h00010; m0_rstrb = 1'b1;
        m1_addr = 20'h00008; m1_rstrb = 1'b1;
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (m1_rbusy !== 1'b1) begin failures++; $display("FAIL rst_defer_setup: got %b expected 1", m1_rbusy); end
        reset = 1'b0;
        #1;
        checks++;
        if (m1_rbusy !== 1'b0 || m0_rbusy !== 1'b0) begin
            failures++; $display("FAIL rst_async_busy: got m0=%b m1=%b expected 0 0", m0_rbusy, m1_rbusy);
        end
        checks++;
        if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
            failures++; $display("FAIL rst_async_rdata: got %h %h expected 0 0", m0_rdata, m1_rdata);
        end
        checks++;
        if (ram_en !== 1'b0) begin failures++; $display("FAIL rst_async_en: got %b expected 0", ram_en); end
        next_cycle();
        next_cycle();
        reset = 1'b1;
        en_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ram_en === 1'b1 || m1_rbusy === 1'b1) en_seen++;
            next_cycle();
        end
        checks++;
        if (en_seen !== 0) begin failures++; $display("FAIL rst_no_replay: got %0d active cycles expected 0", en_seen); end
    endtask

`ifdef ARB_STATS_EN
    task automatic test_conflict_count();
        @(negedge clk);
        checks++;
        if (conflict_count !== 16'h0000) begin failures++; $display("FAIL stats_start: got %h expected 0000", conflict_count); end
        for (int i = 0; i < 70000; i++) begin
            next_cycle();
            m0_addr = 20'h00000; m1_addr = 20'h00000;
            m0_rstrb = (i == 0) || (i % 2 == 1);
            m1_rstrb = (i % 2 == 0);
            if (i == 10) begin
                @(negedge clk);
                checks++;
                if (conflict_count !== 16'd10) begin failures++; $display("FAIL stats_count10: got %0d expected 10", conflict_count); end
            end
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (conflict_count !== 16'hFFFF) begin failures++; $display("FAIL stats_saturate: got %h expected ffff", conflict_count); end
        next_cycle();
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h10000000 + i;
        mem[8'h10] = 32'hDEADBEEF;
        mem[8'h04] = 32'h44444444;
        mem[8'h08] = 32'h88888888;
        mem[8'h20] = 32'h12345678;

        test_reset();
        test_uncontended_read();
        test_back_to_back();
        test_read_tie();
        test_write_read_tie();
        test_pending_beats_fresh();
        test_reset_mid_defer();
`ifdef ARB_STATS_EN
        test_conflict_count();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
